jtag_tap_ctrl: RTL and testbench

- Parametrised IEEE 1149.1 TAP controller. This is the slave/DUT side behind the jtag slave modport (tdi, tms in; tdo out).
- Generalises the fixed 4-pin JTAG link to a configurable IR width and N user data-register channels, with BYPASS and IDCODE.
- Exports captured/updated DR contents to on-chip test logic (pad, reset and debug registers).

---
 rtl/jtag_tap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, BYPASS and NUM_DR user data registers.
// Define JTAG_IDCODE_EN to include the IDCODE register; otherwise reset/TLR selects BYPASS.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  NUM_DR     = 2,
  parameter int                  DR_WIDTH   = 32,
  parameter logic [IR_WIDTH-1:0] USER_BASE  = 4'h8,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 4'h1,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_563F
) (
  input  logic                       tck,
  input  logic                       trst,
  input  logic                       tms,
  input  logic                       tdi,
  output logic                       tdo,
  output logic                       tdo_en,
  output logic [3:0]                 tap_state,
  output logic [IR_WIDTH-1:0]        ir_out,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_cap_data,
  output logic [NUM_DR*DR_WIDTH-1:0] dr_upd_data,
  output logic [NUM_DR-1:0]          dr_upd_pulse
);

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_t;

  tap_state_t          state_reg, state_next;
  logic [IR_WIDTH-1:0] ir_sr_reg;
  logic [DR_WIDTH-1:0] user_sr_reg;
  logic [DR_WIDTH-1:0] cap_val;
  logic                bypass_reg;
  logic [NUM_DR-1:0]   ch_hit;
  logic                user_sel, id_sel, byp_sel, id_lsb;
  logic                in_cap_dr, in_shift_dr, in_upd_dr, in_cap_ir, in_shift_ir;
  logic                enter_upd_dr, enter_upd_ir, enter_tlr;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OP;
  logic [31:0] id_sr_reg;

  assign id_sel = (ir_out == IDCODE_OP) && !user_sel;
  assign id_lsb = id_sr_reg[0];

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      id_sr_reg <= '0;
    end else if (in_cap_dr && id_sel) begin
      id_sr_reg <= IDCODE_VAL;
    end else if (in_shift_dr && id_sel) begin
      id_sr_reg <= {tdi, id_sr_reg[31:1]};
    end
  end
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
  logic unused_idcode;

  assign unused_idcode = ^{IDCODE_VAL, IDCODE_OP};
  assign id_sel = 1'b0;
  assign id_lsb = 1'b0;
`endif

  // Channel decode; the all-ones opcode always stays BYPASS.
  for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_ch
    logic [DR_WIDTH-1:0] upd_reg;

    assign ch_hit[gi] = (ir_out == IR_WIDTH'(USER_BASE + gi)) && (ir_out != '1);
    assign dr_upd_pulse[gi] = in_upd_dr & ch_hit[gi];
    assign dr_upd_data[gi*DR_WIDTH +: DR_WIDTH] = upd_reg;

    always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
        upd_reg <= '0;
      end else if (enter_upd_dr && ch_hit[gi]) begin
        upd_reg <= user_sr_reg;
      end
    end
  end

  assign user_sel  = |ch_hit;
  assign byp_sel   = !user_sel && !id_sel;
  assign tap_state = state_reg;

  always_comb begin
    cap_val = '0;
    for (int i = 0; i < NUM_DR; i++) begin
      if (ch_hit[i]) cap_val = cap_val | dr_cap_data[i*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_reg <= TLR;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      TLR:      state_next = tms ? TLR      : RTI;
      RTI:      state_next = tms ? SEL_DR   : RTI;
      SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_next = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_next = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_next = tms ? SEL_DR   : RTI;
      SEL_IR:   state_next = tms ? TLR      : CAP_IR;
      CAP_IR:   state_next = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_next = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_next = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_next = tms ? SEL_DR   : RTI;
      default:  state_next = TLR;
    endcase
  end

  always_comb begin
    in_cap_dr    = (state_reg == CAP_DR);
    in_shift_dr  = (state_reg == SHIFT_DR);
    in_upd_dr    = (state_reg == UPD_DR);
    in_cap_ir    = (state_reg == CAP_IR);
    in_shift_ir  = (state_reg == SHIFT_IR);
    enter_upd_dr = (state_next == UPD_DR);
    enter_upd_ir = (state_next == UPD_IR);
    enter_tlr    = (state_next == TLR);
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr_reg <= '0;
      ir_out    <= IR_RESET;
    end else begin
      if (in_cap_ir)        ir_sr_reg <= IR_WIDTH'(1);
      else if (in_shift_ir) ir_sr_reg <= {tdi, ir_sr_reg[IR_WIDTH-1:1]};
      if (enter_tlr)         ir_out <= IR_RESET;
      else if (enter_upd_ir) ir_out <= ir_sr_reg;
    end
  end

  // User channels share one shift register since only one is selected at a time.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      user_sr_reg <= '0;
      bypass_reg  <= 1'b0;
    end else begin
      if (in_cap_dr && user_sel)        user_sr_reg <= cap_val;
      else if (in_shift_dr && user_sel) user_sr_reg <= {tdi, user_sr_reg[DR_WIDTH-1:1]};
      if (in_cap_dr && byp_sel)         bypass_reg <= 1'b0;
      else if (in_shift_dr && byp_sel)  bypass_reg <= tdi;
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= in_shift_dr | in_shift_ir;
      if (in_shift_ir)      tdo <= ir_sr_reg[0];
      else if (in_shift_dr) tdo <= user_sel ? user_sr_reg[0] : (id_sel ? id_lsb : bypass_reg);
      else                  tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized bench for jtag_tap_ctrl against a queue-based scan model and a state transition table.
`timescale 1ns/1ps
module tb_jtag_tap_ctrl;
  localparam int          IR_WIDTH   = 4;
  localparam int          NUM_DR     = 2;
  localparam int          DR_WIDTH   = 32;
  localparam logic [3:0]  USER_BASE  = 4'h8;
  localparam logic [3:0]  IDCODE_OP  = 4'h1;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_563F;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] IR_RST = IDCODE_OP;
`else
  localparam logic [3:0] IR_RST = 4'hF;
`endif

  logic tck = 1'b0, trst = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic tdo, tdo_en;
  logic [3:0] tap_state, ir_out;
  logic [NUM_DR*DR_WIDTH-1:0] dr_cap_data = '0, dr_upd_data;
  logic [NUM_DR-1:0] dr_upd_pulse;

  jtag_tap_ctrl #(.IR_WIDTH(IR_WIDTH), .NUM_DR(NUM_DR), .DR_WIDTH(DR_WIDTH),
                  .USER_BASE(USER_BASE), .IDCODE_OP(IDCODE_OP), .IDCODE_VAL(IDCODE_VAL)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state(tap_state), .ir_out(ir_out), .dr_cap_data(dr_cap_data),
    .dr_upd_data(dr_upd_data), .dr_upd_pulse(dr_upd_pulse));

  always #5 tck = ~tck;

  int vectors = 0, miscompares = 0;
  // Standard 1149.1 successor table, indexed by state code.
  int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  int model_state = 15;
  logic [DR_WIDTH-1:0] exp_upd [NUM_DR];

  logic [NUM_DR-1:0] pulse_acc;
  int upd_cycles, en_cycles, idle_tdo_bad, out_n;
  logic [127:0] out_bits;

  task automatic clear_obs();
    pulse_acc = '0; upd_cycles = 0; en_cycles = 0; idle_tdo_bad = 0; out_n = 0; out_bits = '0;
  endtask

  // One tck cycle: sample what the DUT presents in the current state, then clock.
  task automatic step(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    if (dr_upd_pulse != '0) begin upd_cycles++; pulse_acc |= dr_upd_pulse; end
    if (tdo_en === 1'b1) en_cycles++;
    if (model_state == 2 || model_state == 10) begin
      if (out_n < 128) out_bits[out_n] = tdo;
      out_n++;
    end else if (tdo !== 1'b0) idle_tdo_bad++;
    model_state = tms_v ? nxt1[model_state] : nxt0[model_state];
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic apply_reset();
    trst = 1'b0;
    #2;
    trst = 1'b1;
    model_state = 15;
    for (int i = 0; i < NUM_DR; i++) exp_upd[i] = '0;
  endtask

  task automatic goto_rti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Shift model: the register's bits leave LSB first, tdi bits enter behind them.
  task automatic model_scan(input int len, input logic [63:0] cap, input logic [127:0] din,
                            input int n, output logic [127:0] out, output logic [63:0] fin);
    bit q[$];
    out = '0;
    fin = '0;
    for (int i = 0; i < len; i++) q.push_back(cap[i]);
    for (int i = 0; i < n; i++) begin
      out[i] = q.pop_front();
      q.push_back(din[i]);
    end
    for (int i = 0; i < len; i++) fin[i] = q[i];
  endtask

  function automatic logic [NUM_DR*DR_WIDTH-1:0] pack_upd();
    logic [NUM_DR*DR_WIDTH-1:0] v;
    for (int i = 0; i < NUM_DR; i++) v[i*DR_WIDTH +: DR_WIDTH] = exp_upd[i];
    return v;
  endfunction

  task automatic load_ir(input logic [3:0] code, output logic [3:0] cap);
    clear_obs();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < IR_WIDTH; k++) step(k == IR_WIDTH - 1, code[k]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    cap = out_bits[3:0];
  endtask

  task automatic scan_dr(input int n, input int pause_at, input logic [127:0] din);
    clear_obs();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      step((k == n - 1) || (k == pause_at - 1), din[k]);
      if (k == pause_at - 1 && k != n - 1) begin
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    vectors++; if (tap_state !== 4'hF) begin miscompares++; $display("FAIL reset_state got=%h exp=F", tap_state); end
    vectors++; if (ir_out !== IR_RST) begin miscompares++; $display("FAIL reset_ir got=%h exp=%h", ir_out, IR_RST); end
    vectors++; if (dr_upd_data !== pack_upd()) begin miscompares++; $display("FAIL reset_upd got=%h exp=%h", dr_upd_data, pack_upd()); end
    vectors++; if (dr_upd_pulse !== '0) begin miscompares++; $display("FAIL reset_pulse got=%b exp=0", dr_upd_pulse); end
    vectors++; if (tdo !== 1'b0) begin miscompares++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    vectors++; if (tdo_en !== 1'b0) begin miscompares++; $display("FAIL reset_tdo_en got=%b exp=0", tdo_en); end
    $display("reset: state=%h ir=%h", tap_state, ir_out);
  endtask

  task automatic test_idcode(input int n, input logic [127:0] din);
    logic [127:0] eo; logic [63:0] ef;
    apply_reset();
    step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
    model_scan(32, {32'h0, IDCODE_VAL}, din, n, eo, ef);
`else
    model_scan(1, 64'h0, din, n, eo, ef);
`endif
    scan_dr(n, 0, din);
    vectors++; if (out_bits !== eo) begin miscompares++; $display("FAIL idcode_tdo got=%h exp=%h", out_bits, eo); end
    vectors++; if (upd_cycles !== 0) begin miscompares++; $display("FAIL idcode_noupd got=%0d exp=0", upd_cycles); end
    vectors++; if (en_cycles !== n) begin miscompares++; $display("FAIL idcode_en got=%0d exp=%0d", en_cycles, n); end
    $display("idcode scan n=%0d tdo=%h", n, out_bits);
  endtask

  task automatic test_user(input int ch, input int n, input int pause_at,
                           input logic [DR_WIDTH-1:0] cap, input logic [127:0] din);
    logic [3:0] irc, eirc_v; logic [127:0] eo, eirc; logic [63:0] ef, efir;
    logic [3:0] code;
    code = USER_BASE + 4'(ch);
    for (int i = 0; i < NUM_DR; i++) dr_cap_data[i*DR_WIDTH +: DR_WIDTH] = DR_WIDTH'($urandom);
    dr_cap_data[ch*DR_WIDTH +: DR_WIDTH] = cap;
    load_ir(code, irc);
    model_scan(IR_WIDTH, 64'h1, {124'h0, code}, IR_WIDTH, eirc, efir);
    eirc_v = eirc[3:0];
    vectors++; if (irc !== eirc_v) begin miscompares++; $display("FAIL ir_capture got=%b exp=%b", irc, eirc_v); end
    vectors++; if (ir_out !== code) begin miscompares++; $display("FAIL ir_update got=%h exp=%h", ir_out, code); end
    model_scan(DR_WIDTH, {32'h0, cap}, din, n, eo, ef);
    exp_upd[ch] = ef[DR_WIDTH-1:0];
    scan_dr(n, pause_at, din);
    vectors++; if (out_bits !== eo) begin miscompares++; $display("FAIL user_tdo got=%h exp=%h", out_bits, eo); end
    vectors++; if (dr_upd_data !== pack_upd()) begin miscompares++; $display("FAIL user_upd got=%h exp=%h", dr_upd_data, pack_upd()); end
    vectors++; if (pulse_acc !== NUM_DR'(1 << ch) || upd_cycles !== 1) begin
      miscompares++; $display("FAIL user_pulse got=%b/%0d exp=%b/1", pulse_acc, upd_cycles, NUM_DR'(1 << ch)); end
    vectors++; if (en_cycles !== n || idle_tdo_bad !== 0) begin
      miscompares++; $display("FAIL user_tdo_en got=%0d/%0d exp=%0d/0", en_cycles, idle_tdo_bad, n); end
    $display("user ch=%0d n=%0d pause=%0d upd=%h", ch, n, pause_at, dr_upd_data);
  endtask

  task automatic test_bypass(input logic [3:0] code, input int n, input logic [127:0] din);
    logic [3:0] irc; logic [127:0] eo; logic [63:0] ef;
    load_ir(code, irc);
    vectors++; if (irc !== 4'b0001) begin miscompares++; $display("FAIL byp_ir_capture got=%b exp=0001", irc); end
    model_scan(1, 64'h0, din, n, eo, ef);
    scan_dr(n, 0, din);
    vectors++; if (out_bits !== eo) begin miscompares++; $display("FAIL bypass_tdo got=%h exp=%h", out_bits, eo); end
    vectors++; if (en_cycles !== n || upd_cycles !== 0) begin
      miscompares++; $display("FAIL bypass_en got=%0d/%0d exp=%0d/0", en_cycles, upd_cycles, n); end
    vectors++; if (dr_upd_data !== pack_upd()) begin miscompares++; $display("FAIL bypass_upd got=%h exp=%h", dr_upd_data, pack_upd()); end
    $display("bypass ir=%h n=%0d tdo=%h", code, n, out_bits);
  endtask

  task automatic test_tlr_all();
    for (int t = 0; t < 16; t++) begin
      int steps;
      goto_rti();
      steps = 0;
      while (model_state != t && steps < 400) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        steps++;
      end
      vectors++; if (tap_state !== 4'(model_state)) begin
        miscompares++; $display("FAIL walk_state got=%h exp=%h", tap_state, 4'(model_state)); end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      vectors++; if (tap_state !== 4'hF || ir_out !== IR_RST || dr_upd_data !== pack_upd()) begin
        miscompares++; $display("FAIL tlr_from_%h got=%h/%h/%h exp=F/%h/%h", 4'(t), tap_state, ir_out, dr_upd_data, IR_RST, pack_upd()); end
      step(1'b0, 1'b0);
      vectors++; if (tap_state !== 4'hC) begin miscompares++; $display("FAIL tlr_to_rti got=%h exp=C", tap_state); end
      $display("tlr from %h: state=%h", 4'(t), tap_state);
    end
  endtask

  task automatic test_trst_mid_shift();
    logic [3:0] irc;
    goto_rti();
    load_ir(USER_BASE, irc);
    clear_obs();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'($urandom_range(0, 1)));
    trst = 1'b0;
    #1;
    vectors++; if (tap_state !== 4'hF || tdo !== 1'b0 || tdo_en !== 1'b0 || ir_out !== IR_RST) begin
      miscompares++; $display("FAIL trst_async got=%h/%b/%b/%h exp=F/0/0/%h", tap_state, tdo, tdo_en, ir_out, IR_RST); end
    vectors++; if (dr_upd_data !== '0 || dr_upd_pulse !== '0) begin
      miscompares++; $display("FAIL trst_upd got=%h/%b exp=0/0", dr_upd_data, dr_upd_pulse); end
    #1;
    trst = 1'b1;
    model_state = 15;
    for (int i = 0; i < NUM_DR; i++) exp_upd[i] = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    vectors++; if (upd_cycles !== 0 || tap_state !== 4'hC || dr_upd_data !== '0) begin
      miscompares++; $display("FAIL trst_release got=%0d/%h/%h exp=0/C/0", upd_cycles, tap_state, dr_upd_data); end
    $display("trst mid shift: state=%h upd=%h", tap_state, dr_upd_data);
  endtask

  initial begin
    logic [127:0] rnd;
    repeat (2) @(negedge tck);
    #1;
    apply_reset();
    test_reset();
    test_idcode(32, 128'h0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    test_idcode(48, rnd);
    test_user(1, 32, 0, 32'hDEAD_BEEF, 128'h1234_5678);
    test_user(0, 32, 12, DR_WIDTH'($urandom), {96'h0, $urandom});
    for (int it = 0; it < 9; it++) begin
      int n, pa;
      case (it % 3)
        0:       n = DR_WIDTH;
        1:       n = $urandom_range(1, 8);
        default: n = DR_WIDTH + $urandom_range(1, 40);
      endcase
      pa = (it % 2 == 1 && n > 2) ? $urandom_range(1, n - 1) : 0;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      test_user($urandom_range(0, NUM_DR - 1), n, pa, DR_WIDTH'($urandom), rnd);
    end
    test_bypass(4'hF, 5, 128'b01011);
    for (int it = 0; it < 5; it++) begin
      logic [3:0] ops [5];
      ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h7; ops[3] = 4'hA; ops[4] = 4'hF;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      test_bypass(ops[it], $urandom_range(1, 20), rnd);
    end
`ifndef JTAG_IDCODE_EN
    rnd = {$urandom, $urandom, $urandom, $urandom};
    test_bypass(IDCODE_OP, 12, rnd);
`endif
    test_tlr_all();
    goto_rti();
    test_user(0, 20, 0, DR_WIDTH'($urandom), {96'h0, $urandom});
    test_trst_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
